// File: rtl/nn_config_pkg.sv
// Layer sizes for the neuron pipeline and the serializer state encoding.
package nn_config_pkg;
    localparam int NN_L1      = 30;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 8;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
endpackage

// File: rtl/layer_serializer.sv
// Gathers per-lane layer results, then streams them one per cycle (lane 0 two cycles after the last lane lands), no backpressure.
// Define LAYER_SER_OVERRUN_CNT_EN to add the saturating overrun_cnt port.
module layer_serializer
    import nn_config_pkg::*;
#(
    parameter int nn         = NN_L1,
    parameter int data_width = DATA_WIDTH
`ifdef LAYER_SER_OVERRUN_CNT_EN
    ,
    parameter int cnt_width  = CNT_WIDTH
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [nn-1:0]              i_valid,
    input  logic [nn*data_width-1:0]   i_data_flat,
    output logic                       x_valid,
    output logic [data_width-1:0]      x_out,
    output logic                       x_last,
    output logic                       busy
`ifdef LAYER_SER_OVERRUN_CNT_EN
    ,
    output logic [cnt_width-1:0]       overrun_cnt
`endif
);

    localparam int IW = (nn > 1) ? $clog2(nn) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(nn - 1);

    logic [data_width-1:0] cap_bank   [nn];
    logic [data_width-1:0] shift_bank [nn];
    logic [nn-1:0]         mask;
    logic [nn-1:0]         cap_en;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    ser_state_t            state;
    logic                  full;
    logic                  last_cycle;
    logic                  transfer;

    always_comb begin
        full       = &mask;
        last_cycle = (state == SER_SHIFT) && (idx == LAST_IDX);
        transfer   = full && ((state == SER_IDLE) || last_cycle);
        idx_nxt    = idx + 1'b1;
        // A transfer empties the capture bank on this same edge, so every pulse lands
        cap_en     = transfer ? i_valid : (i_valid & ~mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            idx     <= '0;
            state   <= SER_IDLE;
            x_valid <= 1'b0;
            x_out   <= '0;
            x_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            mask <= (transfer ? '0 : mask) | cap_en;
            if (transfer) begin
                state   <= SER_SHIFT;
                idx     <= '0;
                x_valid <= 1'b1;
                x_out   <= cap_bank[0];
                x_last  <= (LAST_IDX == '0);
                busy    <= 1'b1;
            end else if (state == SER_SHIFT) begin
                if (last_cycle) begin
                    state   <= SER_IDLE;
                    idx     <= '0;
                    x_valid <= 1'b0;
                    x_out   <= '0;
                    x_last  <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    idx    <= idx_nxt;
                    x_out  <= shift_bank[idx_nxt];
                    x_last <= (idx_nxt == LAST_IDX);
                end
            end
        end
    end

    // Data banks carry no reset: the mask and state decide what is ever read out
    always_ff @(posedge clk) begin
        for (int j = 0; j < nn; j++) begin
            if (cap_en[j]) cap_bank[j] <= i_data_flat[j*data_width +: data_width];
        end
        if (transfer) shift_bank <= cap_bank;
    end

`ifdef LAYER_SER_OVERRUN_CNT_EN
    localparam int PW = $clog2(nn + 1);
    localparam int SW = ((cnt_width > PW) ? cnt_width : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({cnt_width{1'b1}});

    logic [nn-1:0] overrun;
    logic [PW-1:0] ov_num;
    logic [SW-1:0] cnt_sum;

    always_comb begin
        overrun = transfer ? '0 : (i_valid & mask);
        ov_num  = '0;
        for (int j = 0; j < nn; j++) ov_num = ov_num + PW'(overrun[j]);
        cnt_sum = SW'(overrun_cnt) + SW'(ov_num);
    end

    always_ff @(posedge clk) begin
        if (rst)                    overrun_cnt <= '0;
        else if (cnt_sum > CNT_MAX) overrun_cnt <= '1;
        else                        overrun_cnt <= cnt_width'(cnt_sum);
    end
`endif

endmodule
